// File: rtl/logic_result_display.sv
// ============================================================================
// Module  : logic_result_display
// Purpose : 8-digit multiplexed seven-segment back-end that shows the op mnemonic and hex result.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_result_display #(
   parameter int SCAN_DIV    = 100000,
   parameter int FLASH_TICKS = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] result,
   input  logic [1:0] state,
   input  logic       enable,
   output logic [7:0] seg,
   output logic [7:0] an
);

   localparam int DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int FLASH_W = $clog2(FLASH_TICKS + 1);
   localparam logic [DIV_W-1:0]   c_DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [FLASH_W-1:0] c_FLASH_LOAD = FLASH_W'(FLASH_TICKS);

   logic [7:0]         result_q;
   logic [1:0]         state_q;
   logic               enable_q;
   logic [1:0]         prev_state_q;
   logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
   logic [2:0]         dig_idx_q,   dig_idx_d;
   logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
   logic [7:0]         seg_q,       seg_d;
   logic [7:0]         an_q,        an_d;
   logic               w_tick;
   logic               w_op_change;

   function automatic logic [7:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 8'hFC;  4'h1: hex_glyph = 8'h60;
         4'h2: hex_glyph = 8'hDA;  4'h3: hex_glyph = 8'hF2;
         4'h4: hex_glyph = 8'h66;  4'h5: hex_glyph = 8'hB6;
         4'h6: hex_glyph = 8'hBE;  4'h7: hex_glyph = 8'hE0;
         4'h8: hex_glyph = 8'hFE;  4'h9: hex_glyph = 8'hF6;
         4'hA: hex_glyph = 8'hEE;  4'hB: hex_glyph = 8'h3E;
         4'hC: hex_glyph = 8'h9C;  4'hD: hex_glyph = 8'h7A;
         4'hE: hex_glyph = 8'h9E;  default: hex_glyph = 8'h8E;
      endcase
   endfunction

   // Glyph for mnemonic digits 7..5; {op, digit} selects the letter.
   function automatic logic [7:0] mnem_glyph(input logic [1:0] op, input logic [2:0] dig);
      case ({op, dig})
         5'b00_111: mnem_glyph = 8'hEE;  5'b00_110: mnem_glyph = 8'h2A;
         5'b00_101: mnem_glyph = 8'h7A;  5'b01_111: mnem_glyph = 8'h3A;
         5'b01_110: mnem_glyph = 8'h0A;  5'b10_111: mnem_glyph = 8'h2A;
         5'b10_110: mnem_glyph = 8'h3A;  5'b10_101: mnem_glyph = 8'h1E;
         5'b11_111: mnem_glyph = 8'h6E;  5'b11_110: mnem_glyph = 8'h3A;
         5'b11_101: mnem_glyph = 8'h0A;  default:   mnem_glyph = 8'h00;
      endcase
   endfunction

   always_comb begin
      w_tick      = (div_cnt_q == c_DIV_LAST);
      w_op_change = (state_q != prev_state_q);
      div_cnt_d   = w_tick ? '0 : div_cnt_q + 1'b1;
      dig_idx_d   = w_tick ? dig_idx_q + 3'd1 : dig_idx_q;

      flash_cnt_d = flash_cnt_q;
      if (w_op_change) begin
         flash_cnt_d = c_FLASH_LOAD;
      end else if (w_tick && (flash_cnt_q != '0)) begin
         flash_cnt_d = flash_cnt_q - 1'b1;
      end

      seg_d = 8'h00;
      if (dig_idx_q >= 3'd5) begin
         if (flash_cnt_q == '0) begin
            seg_d = mnem_glyph(state_q, dig_idx_q);
         end
      end else if (dig_idx_q == 3'd1) begin
         seg_d = hex_glyph(result_q[7:4]);
      end else if (dig_idx_q == 3'd0) begin
         seg_d = hex_glyph(result_q[3:0]);
      end
      if (!enable_q) begin
         seg_d = 8'h00;
      end

      an_d = 8'h01 << dig_idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q     <= '0;
         state_q      <= '0;
         enable_q     <= 1'b0;
         prev_state_q <= '0;
         div_cnt_q    <= '0;
         dig_idx_q    <= '0;
         flash_cnt_q  <= '0;
         seg_q        <= 8'h00;
         an_q         <= 8'h01;
      end else begin
         result_q     <= result;
         state_q      <= state;
         enable_q     <= enable;
         prev_state_q <= state_q;
         div_cnt_q    <= div_cnt_d;
         dig_idx_q    <= dig_idx_d;
         flash_cnt_q  <= flash_cnt_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_result_display.sv
// ============================================================================
// Module  : tb_logic_result_display
// Purpose : Directed scoreboard bench for logic_result_display (SCAN_DIV=4, FLASH_TICKS=3).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_result_display;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] result;
   logic [1:0] state;
   logic       enable;
   logic [7:0] seg;
   logic [7:0] an;

   int          checks   = 0;
   int          failures = 0;
   int          exp_dig;
   int          flash_left;
   logic [15:0] sb[$];

   logic_result_display #(.SCAN_DIV(4), .FLASH_TICKS(3)) dut (
      .clk(clk), .reset(reset), .result(result), .state(state),
      .enable(enable), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] hexg(input logic [3:0] v);
      logic [127:0] tbl;
      tbl = 128'hFC60DAF266B6BEE0FEF6EE3E9C7A9E8E;
      return tbl[(15 - int'(v)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] exp_glyph(input int dig, input bit blank);
      logic [23:0] m;
      if (!enable) return 8'h00;
      case (state)
         2'b00:   m = 24'hEE2A7A;
         2'b01:   m = 24'h3A0A00;
         2'b10:   m = 24'h2A3A1E;
         default: m = 24'h6E3A0A;
      endcase
      if (dig >= 5) return blank ? 8'h00 : m[(dig - 5) * 8 +: 8];
      if (dig == 1) return hexg(result[7:4]);
      if (dig == 0) return hexg(result[3:0]);
      return 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // Predict the next digit slot, wait for an to move, then compare mid-slot.
   task automatic next_slot(input bit chk_period);
      int          n;
      logic [7:0]  old;
      logic [15:0] e;
      bit          blank;
      exp_dig = (exp_dig + 1) % 8;
      blank   = (flash_left > 0);
      if (flash_left > 0) flash_left--;
      sb.push_back({8'(1 << exp_dig), exp_glyph(exp_dig, blank)});
      old = an;
      n   = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an === old && n < 12);
      if (n >= 12) begin
         checks++;
         failures++;
         $error("FAIL slot_timeout observed=an_stuck_%02h expected=an_change", an);
      end
      @(negedge clk);
      if (chk_period) chk("period", 8'(n), 8'd3);
      e = sb.pop_front();
      chk($sformatf("an_d%0d", exp_dig), an, e[15:8]);
      chk($sformatf("seg_d%0d", exp_dig), seg, e[7:0]);
   endtask

   initial begin
      reset      = 1'b1;
      state      = 2'b00;
      result     = 8'h3C;
      enable     = 1'b1;
      exp_dig    = 0;
      flash_left = 0;

      // Reset state and scan stepping through two full rotations.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_an", an, 8'h01);
      chk("rst_seg", seg, 8'h00);
      reset = 1'b0;
      next_slot(1'b0);
      repeat (15) next_slot(1'b1);

      // AND -> XOR while digit 4 is lit: digits 7..5 blank, then XOR mnemonic.
      repeat (4) next_slot(1'b1);
      state = 2'b11; flash_left = 3;
      repeat (11) next_slot(1'b1);

      // Second change one tick into a flash restarts the blank period.
      repeat (4) next_slot(1'b1);
      state = 2'b01; flash_left = 3;
      next_slot(1'b1);
      state = 2'b10; flash_left = 3;
      repeat (4) next_slot(1'b1);
      result = 8'hA5;
      repeat (8) next_slot(1'b1);

      // Display disabled for 10 slots, restored mid-slot on digit 1.
      enable = 1'b0;
      repeat (9) next_slot(1'b1);
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("en_restore_an", an, 8'h02);
      chk("en_restore_seg", seg, exp_glyph(1, 1'b0));
      next_slot(1'b0);
      next_slot(1'b1);

      // Reset while digit 5 is blanked by a flash.
      state = 2'b11; flash_left = 3;
      next_slot(1'b1);
      next_slot(1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_an", an, 8'h01);
      chk("midrst_seg", seg, 8'h00);
      reset = 1'b0;
      exp_dig = 0; flash_left = 0;
      next_slot(1'b0);
      repeat (6) next_slot(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
